// File: rtl/fp2int_pipe.sv
// fp2int_pipe: two-stage float-to-integer converter with valid/ready flow control.
// Define FP2INT_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp2int_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int INT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   fp_i,
    input  logic                   signed_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [INT_W-1:0]       int_o,
    output logic [2:0]             flag_o
);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int FR = MAN_W + 2;
    localparam int XW = INT_W + FR;
    localparam int EW = (EXP_W > 8 ? EXP_W : 8) + 2;
    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_LO = EW'(-2);
    localparam logic signed [EW-1:0] E_HI = EW'(INT_W);
    localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W:0] NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};

    logic                   r1_valid, r1_sign, r1_signed, r1_nan, r1_inf, r1_zero, r1_sub, r1_big, r1_g, r1_st;
    logic [INT_W-1:0]       r1_mag;
    logic                   r2_valid;
    logic [INT_W-1:0]       r2_int;
    logic [2:0]             r2_flag;
    logic [EXP_W-1:0]       w_exp;
    logic [MAN_W-1:0]       w_man;
    logic signed [EW-1:0]   w_e;
    logic [EW-1:0]          w_shamt;
    logic [XW-1:0]          w_x;
    logic                   w_exp_max, w_exp_zero, w_man_nz, w_s1_ld, w_s2_ld;
    logic [INT_W:0]         w_rmag;
    logic                   w_inex, w_rzero, w_ovf;
    logic [INT_W-1:0]       w_int;
    logic [2:0]             w_flag;

    assign w_exp      = fp_i[EXP_W+MAN_W-1:MAN_W];
    assign w_man      = fp_i[MAN_W-1:0];
    assign w_exp_max  = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_man_nz   = |w_man;
    assign w_e        = $signed({{(EW-EXP_W){1'b0}}, w_exp}) - E_BIAS;
    // Fixed point with FR fraction bits: guard at FR-1, sticky below it
    assign w_shamt    = w_e - E_LO;
    assign w_x        = {{(XW-MAN_W-1){1'b0}}, 1'b1, w_man} << w_shamt;

    assign w_s2_ld    = !r2_valid | out_ready_i;
    assign w_s1_ld    = !r1_valid | w_s2_ld;
    assign in_ready_o = w_s1_ld & !rst_i;

    always_ff @(posedge clk_i) begin
        if (w_s1_ld & in_valid_i) begin
            r1_sign   <= fp_i[EXP_W+MAN_W];
            r1_signed <= signed_i;
            r1_nan    <= w_exp_max & w_man_nz;
            r1_inf    <= w_exp_max & !w_man_nz;
            r1_zero   <= w_exp_zero & !w_man_nz;
            r1_sub    <= w_exp_zero & w_man_nz;
            r1_big    <= !w_exp_zero & !w_exp_max & (w_e >= E_HI);
            r1_mag    <= w_x[XW-1:FR];
            r1_g      <= w_x[FR-1];
            r1_st     <= (|w_x[FR-2:0]) | (w_e < E_LO);
        end
    end

`ifdef FP2INT_RNE_EN
    assign w_rmag = {1'b0, r1_mag} + {{INT_W{1'b0}}, r1_g & (r1_st | r1_mag[0])};
`else
    assign w_rmag = {1'b0, r1_mag};
`endif
    assign w_inex  = r1_g | r1_st;
    assign w_rzero = ~|w_rmag;
    assign w_ovf   = r1_sign ? (w_rmag > NEG_LIM) : r1_signed ? |w_rmag[INT_W:INT_W-1] : w_rmag[INT_W];

    always_comb begin
        w_int  = '0;
        w_flag = 3'b000;
        if (r1_nan) begin
            w_int  = r1_signed ? SMAX : '1;
            w_flag = 3'b001;
        end else if (r1_zero) begin
            w_flag = 3'b000;
        end else if (r1_sub) begin
            w_flag = 3'b110;
        end else if (r1_sign & !r1_signed) begin
            w_flag = {w_inex & !r1_inf, 2'b10};
        end else if (r1_inf | r1_big | w_ovf) begin
            w_int  = r1_sign ? SMIN : r1_signed ? SMAX : '1;
            w_flag = 3'b001;
        end else begin
            w_int  = r1_sign ? -w_rmag[INT_W-1:0] : w_rmag[INT_W-1:0];
            w_flag = {w_inex, w_inex & w_rzero, 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r2_int   <= '0;
            r2_flag  <= 3'b000;
        end else begin
            if (w_s1_ld) r1_valid <= in_valid_i;
            if (w_s2_ld) begin
                r2_valid <= r1_valid;
                if (r1_valid) begin
                    r2_int  <= w_int;
                    r2_flag <= w_flag;
                end
            end
        end
    end

    assign out_valid_o = r2_valid;
    assign int_o       = r2_int;
    assign flag_o      = r2_flag;
endmodule
